// File: rtl/estagio_resultado.sv
`default_nettype none
// ============================================================================
//  Module      : estagio_resultado
//  Description : ALU result / write-back stage. It buffers ALU results in a
//                2-entry FIFO with valid/ready handshakes on both sides.
//                Each entry is decoded once, when it is pushed, into a
//                write-enable and a branch-taken bit. The stage also keeps a
//                sticky overflow-exception flag and a wrapping count of
//                accepted entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module estagio_resultado #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       controle,
    input  logic [WIDTH-1:0] ULAresult,
    input  logic             zero,
    input  logic             negativo,
    input  logic             overflow,
    input  logic [4:0]       rd,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [4:0]       out_rd,
    output logic             out_we,
    output logic [2:0]       out_flags,
    output logic             branch_taken,
    output logic             exc_sticky,
    input  logic             exc_clear,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [4:0] C_OP_BEQ  = 5'd7;
    localparam logic [4:0] C_OP_BNEQ = 5'd8;
    localparam logic [4:0] C_OP_BLZ  = 5'd9;
    localparam logic [4:0] C_OP_BLT  = 5'd18;
    localparam logic [4:0] C_OP_BGRT = 5'd19;
    localparam logic [4:0] C_OP_LAST = 5'd19;

    state_t           state_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [WIDTH-1:0] result_q [2];
    logic [4:0]       rd_q     [2];
    logic [2:0]       flags_q  [2];
    logic             we_q     [2];
    logic             bt_q     [2];
    logic             exc_q;
    logic [15:0]      count_q;

    logic             is_branch_d;
    logic             taken_d;
    logic             we_d;
    logic             push_w;
    logic             pop_w;

    // A push in a flush cycle is dropped. It is not stored, not counted, and
    // does not raise the exception flag.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign push_w    = in_valid && in_ready && !flush;
    assign pop_w     = out_valid && out_ready;

    // Decode the incoming opcode into branch / taken / write-enable.
    always_comb begin
        is_branch_d = 1'b0;
        taken_d     = 1'b0;
        case (controle)
            C_OP_BEQ, C_OP_BLT, C_OP_BGRT: begin
                is_branch_d = 1'b1;
                taken_d     = zero;
            end
            C_OP_BNEQ: begin
                is_branch_d = 1'b1;
                taken_d     = !zero;
            end
            C_OP_BLZ: begin
                is_branch_d = 1'b1;
                taken_d     = negativo;
            end
            default: begin
                is_branch_d = 1'b0;
                taken_d     = 1'b0;
            end
        endcase
        we_d = !is_branch_d && !overflow && (controle <= C_OP_LAST);
    end

    // Occupancy FSM and read/write pointers. A flush empties the FIFO.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push_w) wr_ptr_q <= ~wr_ptr_q;
            if (pop_w)  rd_ptr_q <= ~rd_ptr_q;
            case (state_q)
                ST_EMPTY: if (push_w)           state_q <= ST_ONE;
                ST_ONE:   if (push_w && !pop_w) state_q <= ST_FULL;
                          else if (!push_w && pop_w) state_q <= ST_EMPTY;
                ST_FULL:  if (pop_w)            state_q <= ST_ONE;
                default:                        state_q <= ST_EMPTY;
            endcase
        end
    end

    // Entry storage. Reset clears the entries so the head reads as zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                result_q[i] <= '0;
                rd_q[i]     <= '0;
                flags_q[i]  <= '0;
                we_q[i]     <= 1'b0;
                bt_q[i]     <= 1'b0;
            end
        end else if (push_w) begin
            result_q[wr_ptr_q] <= ULAresult;
            rd_q[wr_ptr_q]     <= rd;
            flags_q[wr_ptr_q]  <= {overflow, negativo, zero};
            we_q[wr_ptr_q]     <= we_d;
            bt_q[wr_ptr_q]     <= taken_d;
        end
    end

    // Sticky overflow flag. A set on the same edge as a clear wins.
    always_ff @(posedge clock) begin
        if (reset)                    exc_q <= 1'b0;
        else if (push_w && overflow)  exc_q <= 1'b1;
        else if (exc_clear)           exc_q <= 1'b0;
    end

    // Count of accepted entries. It wraps naturally and a flush does not touch it.
    always_ff @(posedge clock) begin
        if (reset)       count_q <= '0;
        else if (push_w) count_q <= count_q + 16'd1;
    end

    // The head entry is presented directly from storage. The control bits
    // are gated so they read as 0 whenever the stage is empty.
    assign out_result   = result_q[rd_ptr_q];
    assign out_rd       = rd_q[rd_ptr_q];
    assign out_flags    = flags_q[rd_ptr_q];
    assign out_we       = out_valid && we_q[rd_ptr_q];
    assign branch_taken = out_valid && bt_q[rd_ptr_q];
    assign exc_sticky   = exc_q;
    assign op_count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_estagio_resultado.sv
`default_nettype none
// ============================================================================
//  Module      : tb_estagio_resultado
//  Description : Self-checking bench for estagio_resultado. A queue-based
//                reference model follows every clock edge. Directed tasks
//                and a randomized task compare the DUT against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_estagio_resultado;

    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset, in_valid, in_ready, zero, negativo, overflow;
    logic [4:0]       controle, rd, out_rd;
    logic [WIDTH-1:0] ULAresult, out_result;
    logic             flush, out_valid, out_ready, out_we, branch_taken;
    logic [2:0]       out_flags;
    logic             exc_sticky, exc_clear;
    logic [15:0]      op_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [4:0]       rd;
        logic [2:0]       flags;
        logic             we;
        logic             bt;
    } entry_t;

    entry_t      mq[$];
    logic [15:0] m_cnt;
    logic        m_exc;

    estagio_resultado #(.WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .controle(controle), .ULAresult(ULAresult), .zero(zero),
        .negativo(negativo), .overflow(overflow), .rd(rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_we(out_we), .out_flags(out_flags),
        .branch_taken(branch_taken), .exc_sticky(exc_sticky),
        .exc_clear(exc_clear), .op_count(op_count)
    );

    always #5 clock = ~clock;

    // Reference decode, written from the opcode table.
    function automatic entry_t make_entry();
        entry_t e;
        bit     br;
        e.res   = ULAresult;
        e.rd    = rd;
        e.flags = {overflow, negativo, zero};
        br      = (controle == 7) || (controle == 8) || (controle == 9) ||
                  (controle == 18) || (controle == 19);
        if (controle == 8)      e.bt = !zero;
        else if (controle == 9) e.bt = negativo;
        else if (br)            e.bt = zero;
        else                    e.bt = 1'b0;
        e.we = !(br || overflow || (controle > 19));
        return e;
    endfunction

    // Advance one clock and update the model from the inputs applied to that edge.
    task automatic tick();
        bit push, pop;
        @(posedge clock);
        if (reset) begin
            mq.delete();
            m_cnt = 16'h0;
            m_exc = 1'b0;
        end else begin
            push = in_valid && (mq.size() < 2) && !flush;
            pop  = (mq.size() > 0) && out_ready;
            if (flush) mq.delete();
            else if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(make_entry());
                m_cnt = m_cnt + 16'd1;
            end
            if (push && overflow) m_exc = 1'b1;
            else if (exc_clear)   m_exc = 1'b0;
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [4:0] op, input logic [WIDTH-1:0] r,
                         input bit z, input bit n, input bit o, input logic [4:0] d);
        in_valid = v; controle = op; ULAresult = r;
        zero = z; negativo = n; overflow = o; rd = d;
    endtask

    task automatic idle_drain();
        drive(0, 0, 0, 0, 0, 0, 0);
        flush = 0; exc_clear = 0; out_ready = 1;
        tick(); tick();
    endtask

    task automatic test_reset();
        reset = 1; flush = 0; exc_clear = 0; out_ready = 0;
        drive(1, 0, 32'hDEAD, 1, 1, 1, 5);
        tick(); tick();
        reset = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({out_valid, out_we, branch_taken, out_flags, out_rd, out_result, exc_sticky, op_count}
            !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b we=%b bt=%b fl=%b rd=%0d res=%h exc=%b cnt=%h want all 0",
                     out_valid, out_we, branch_taken, out_flags, out_rd, out_result, exc_sticky, op_count);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        out_ready = 1;
        drive(1, 5'd0, 32'h0000_0005, 0, 0, 0, 5'd3);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({out_valid, out_result, out_rd, out_we, branch_taken, op_count} !==
            {1'b1, 32'd5, 5'd3, 1'b1, 1'b0, 16'd1}) begin
            n_err++;
            $display("FAIL basic_push: got v=%b res=%h rd=%0d we=%b bt=%b cnt=%0d want 1/5/3/1/0/1",
                     out_valid, out_result, out_rd, out_we, branch_taken, op_count);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out_we !== 1'b0) begin
            n_err++; $display("FAIL basic_pop: got v=%b we=%b want 0/0", out_valid, out_we);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] base;
        idle_drain();
        base = m_cnt;
        out_ready = 0;
        drive(1, 5'd1, 32'hA, 0, 0, 0, 5'd1); tick();
        drive(1, 5'd1, 32'hB, 0, 0, 0, 5'd2); tick();
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL b2b_full_ready: got %b want 0", in_ready);
        end
        drive(1, 5'd1, 32'hC, 0, 0, 0, 5'd3); tick();
        n_cmp++;
        if (op_count !== base + 16'd2 || out_result !== 32'hA) begin
            n_err++;
            $display("FAIL b2b_third_dropped: got cnt=%0d head=%h want %0d/a", op_count, out_result, base + 16'd2);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        out_ready = 1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_result !== 32'hB || out_rd !== 5'd2) begin
            n_err++; $display("FAIL b2b_second: got v=%b res=%h rd=%0d want 1/b/2", out_valid, out_result, out_rd);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_drained: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_branches();
        idle_drain();
        drive(1, 5'd7, 32'h11, 1, 0, 0, 5'd4); tick();
        n_cmp++;
        if (branch_taken !== 1'b1 || out_we !== 1'b0) begin
            n_err++; $display("FAIL br_beq: got bt=%b we=%b want 1/0", branch_taken, out_we);
        end
        drive(1, 5'd8, 32'h22, 1, 0, 0, 5'd5); tick();
        n_cmp++;
        if (branch_taken !== 1'b0 || out_we !== 1'b0 || out_result !== 32'h22) begin
            n_err++; $display("FAIL br_bneq: got bt=%b we=%b res=%h want 0/0/22", branch_taken, out_we, out_result);
        end
        drive(1, 5'd9, 32'h33, 0, 1, 0, 5'd6); tick();
        n_cmp++;
        if (branch_taken !== 1'b1 || out_we !== 1'b0 || out_result !== 32'h33) begin
            n_err++; $display("FAIL br_blz: got bt=%b we=%b res=%h want 1/0/33", branch_taken, out_we, out_result);
        end
    endtask

    task automatic test_overflow();
        idle_drain();
        out_ready = 0; exc_clear = 1;
        drive(1, 5'd2, 32'h7FFF_FFFF, 0, 0, 1, 5'd9); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (exc_sticky !== 1'b1 || out_we !== 1'b0 || out_flags !== 3'b100) begin
            n_err++; $display("FAIL ovf_set: got exc=%b we=%b fl=%b want 1/0/100", exc_sticky, out_we, out_flags);
        end
        tick();
        exc_clear = 0;
        n_cmp++;
        if (exc_sticky !== 1'b0) begin
            n_err++; $display("FAIL ovf_clear: got exc=%b want 0", exc_sticky);
        end
    endtask

    task automatic test_flush();
        logic [15:0] base;
        idle_drain();
        base = m_cnt;
        out_ready = 0;
        drive(1, 5'd3, 32'h1, 0, 0, 0, 5'd1); tick();
        drive(1, 5'd3, 32'h2, 0, 0, 0, 5'd2); tick();
        flush = 1;
        drive(1, 5'd3, 32'h3, 0, 0, 0, 5'd3); tick();
        flush = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== base + 16'd2 || out_we !== 1'b0) begin
            n_err++;
            $display("FAIL flush_full: got v=%b rdy=%b cnt=%0d we=%b want 0/1/%0d/0",
                     out_valid, in_ready, op_count, out_we, base + 16'd2);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0, 5'($urandom));
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 19) == 0;
            exc_clear = $urandom_range(0, 9) == 0;
            tick();
            n_cmp++;
            if ({out_valid, in_ready, exc_sticky, op_count} !==
                {mq.size() > 0, mq.size() < 2, m_exc, m_cnt}) begin
                n_err++;
                $display("FAIL rand_ctrl c=%0d: got v=%b rdy=%b exc=%b cnt=%h want %b/%b/%b/%h", c,
                         out_valid, in_ready, exc_sticky, op_count, mq.size() > 0, mq.size() < 2, m_exc, m_cnt);
            end
            n_cmp++;
            if (mq.size() == 0) begin
                if ({out_we, branch_taken} !== 2'b00) begin
                    n_err++; $display("FAIL rand_idle c=%0d: got we=%b bt=%b want 0/0", c, out_we, branch_taken);
                end
            end else if ({out_result, out_rd, out_flags, out_we, branch_taken} !==
                         {mq[0].res, mq[0].rd, mq[0].flags, mq[0].we, mq[0].bt}) begin
                n_err++;
                $display("FAIL rand_head c=%0d: got res=%h rd=%0d fl=%b we=%b bt=%b want %h/%0d/%b/%b/%b", c,
                         out_result, out_rd, out_flags, out_we, branch_taken,
                         mq[0].res, mq[0].rd, mq[0].flags, mq[0].we, mq[0].bt);
            end
        end
        flush = 0; exc_clear = 0;
    endtask

    task automatic test_wrap_and_reset();
        reset = 1; tick(); reset = 0;
        out_ready = 1; flush = 0; exc_clear = 0;
        drive(1, 5'd0, 32'h5, 0, 0, 0, 5'd1);
        for (int i = 0; i < 65535; i++) tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (op_count !== 16'hFFFF) begin
            n_err++; $display("FAIL wrap_preload: got %h want ffff", op_count);
        end
        drive(1, 5'd0, 32'h6, 0, 0, 0, 5'd1); tick();
        n_cmp++;
        if (op_count !== 16'h0000) begin
            n_err++; $display("FAIL wrap_rollover: got %h want 0000", op_count);
        end
        idle_drain();
        out_ready = 0;
        drive(1, 5'd4, 32'hFACE, 1, 1, 1, 5'd7); tick();
        drive(1, 5'd0, 32'hBEEF, 0, 0, 0, 5'd8); tick();
        n_cmp++;
        if (in_ready !== 1'b0 || exc_sticky !== 1'b1) begin
            n_err++; $display("FAIL prereset_full: got rdy=%b exc=%b want 0/1", in_ready, exc_sticky);
        end
        reset = 1; flush = 1; exc_clear = 1; out_ready = 1;
        drive(1, 5'd0, 32'h1234, 1, 1, 1, 5'd9); tick();
        reset = 0; flush = 0; exc_clear = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({out_valid, out_we, branch_taken, out_flags, out_rd, out_result, exc_sticky, op_count} !== '0
            || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_full: got v=%b we=%b bt=%b fl=%b rd=%0d res=%h exc=%b cnt=%h rdy=%b want 0s rdy=1",
                     out_valid, out_we, branch_taken, out_flags, out_rd, out_result, exc_sticky, op_count, in_ready);
        end
    endtask

    initial begin
        m_cnt = 16'h0;
        m_exc = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_branches();
        test_overflow();
        test_flush();
        test_random();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/estagio_resultado.md
ESTAGIO_RESULTADO -- requirements
Module: estagio_resultado

Interface
REQ-001 Parameter WIDTH, default 32, data width of the ALU result and all result paths.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 in_valid  input  1  upstream ALU result valid this cycle.
REQ-005 in_ready  output  1  stage can accept an entry this cycle.
REQ-006 controle  input  5  ALU opcode accompanying the result (adc=0 ... bgrt=19).
REQ-007 ULAresult  input  WIDTH  ALU result.
REQ-008 zero, negativo, overflow  input  1 each  ALU flags.
REQ-009 rd  input  5  destination register index.
REQ-010 flush  input  1  discard all buffered entries.
REQ-011 out_valid  output  1  head entry valid.
REQ-012 out_ready  input  1  downstream accepts the head entry.
REQ-013 out_result  output  WIDTH; out_rd  output  5; out_we  output  1  write-back data, index, enable.
REQ-014 out_flags  output  3  {overflow, negativo, zero} of the head entry.
REQ-015 branch_taken  output  1  head entry is a taken branch.
REQ-016 exc_sticky  output  1  overflow exception seen since last clear; exc_clear  input  1  clears it.
REQ-017 op_count  output  16  number of accepted entries, wraps.

Function
REQ-018 Storage SHALL be a 2-entry FIFO; states EMPTY, ONE, FULL by occupancy.
REQ-019 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL (no combinational path from out_ready).
REQ-021 Transitions: EMPTY-push->ONE; ONE-push-only->FULL; ONE-pop-only->EMPTY; ONE push+pop->ONE; FULL-pop->ONE; otherwise hold.
REQ-022 out_valid SHALL be 1 iff state is ONE or FULL; outputs SHALL present the oldest entry; head values SHALL remain stable while out_valid && !out_ready.
REQ-023 Entry decode at push: branch ops SHALL be beq(7), bneq(8), blz(9), blt(18), bgrt(19).
REQ-024 branch_taken SHALL be zero for beq/blt/bgrt, !zero for bneq, negativo for blz, 0 for non-branch ops.
REQ-025 out_we SHALL be 0 for branch ops, for overflow=1, and for controle>19; 1 otherwise.
REQ-026 out_result, out_rd, out_flags SHALL be the captured inputs unmodified; latency input-to-output exactly 1 cycle when EMPTY.
REQ-027 Accepted entry with overflow=1 SHALL set exc_sticky on the next edge; exc_clear clears it; simultaneous set and clear SHALL leave it set.
REQ-028 op_count SHALL increment by 1 per push, wrapping 0xFFFF->0x0000; unaffected by flush.
REQ-029 flush SHALL empty the FIFO next edge; a push in the flush cycle SHALL be dropped and not counted; exc_sticky unaffected.
REQ-030 Data when out_valid=0 SHALL be don't-care except out_we and branch_taken, which SHALL be 0.

Reset
REQ-031 reset SHALL force state EMPTY, out_valid=0, out_we=0, branch_taken=0, out_flags=0, out_result=0, out_rd=0, exc_sticky=0, op_count=0.
REQ-032 reset SHALL override flush, push, pop and exc_clear in the same cycle; a push during reset SHALL be lost.
REQ-033 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-034 Push adc, ULAresult=0x0000_0005, rd=3, out_ready=1 -> next cycle out_valid=1, out_result=5, out_rd=3, out_we=1, branch_taken=0, op_count=1.
REQ-035 out_ready=0, push three entries back-to-back -> in_ready=0 after second, third not accepted, op_count=2; release out_ready -> entries emerge in order, 1 per cycle.
REQ-036 Push beq zero=1, bneq zero=1, blz negativo=1 -> branch_taken 1,0,1; out_we 0 for all.
REQ-037 Push mult overflow=1 with exc_clear=1 same cycle -> exc_sticky=1, head out_we=0, out_flags=3'b100; later exc_clear alone -> exc_sticky=0.
REQ-038 FULL with flush=1 and in_valid=1 -> next cycle EMPTY, out_valid=0, op_count unchanged.
REQ-039 op_count preloaded to 0xFFFF by 65535 pushes, one more push -> op_count=0x0000; reset mid-FULL -> all outputs per REQ-031 next cycle.
